// File: rtl/line_buffer_writer.sv
// Line-buffer write producer: turns a valid/ready pixel stream into we/wr_addr/data_out/eol line writes.
// Optional horizontal zero padding is compiled in with `define LINE_WRITER_PAD_EN.
`timescale 1ns/1ps
module line_buffer_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int PAD_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] line_width,
  input  logic [ADDR_WIDTH-1:0] num_lines,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  eol,
  output logic                  busy,
  output logic                  done
);

`ifdef LINE_WRITER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int PAD_N = PAD_EN ? PAD_WIDTH : 0;
  // Two spare bits keep the column compare exact even at the maximum line_width plus padding.
  localparam int CW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    WRITE,
    EOL,
    DONE
`ifdef LINE_WRITER_PAD_EN
    ,
    PAD_L,
    PAD_R
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [CW-1:0]         last_col_q;
  logic [ADDR_WIDTH-1:0] last_line_q;
  logic                  lat_en;
  logic                  accept;

  logic                  we_d, eol_d, done_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;

  logic                  we_p1, eol_p1, done_p1, busy_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Column of the last real pixel of a line, computed wide so line_width at max cannot wrap.
  function automatic logic [CW-1:0] end_col(input logic [ADDR_WIDTH-1:0] w);
    return CW'(w) + CW'(PAD_N) - CW'(1);
  endfunction

  assign s_ready = (state_q == WRITE);
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    lat_en  = 1'b0;
    we_d    = 1'b0;
    eol_d   = 1'b0;
    done_d  = 1'b0;
    addr_d  = wr_addr_p1;
    data_d  = data_p1;
    case (state_q)
      IDLE: begin
        if (start && (line_width != '0) && (num_lines != '0)) begin
          lat_en  = 1'b1;
          col_d   = '0;
          line_d  = '0;
          state_d = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (ready) begin
`ifdef LINE_WRITER_PAD_EN
          state_d = PAD_L;
`else
          state_d = WRITE;
`endif
        end
      end
`ifdef LINE_WRITER_PAD_EN
      PAD_L: begin
        we_d   = 1'b1;
        addr_d = col_q[ADDR_WIDTH-1:0];
        data_d = '0;
        col_d  = col_q + 1'b1;
        if (col_q == CW'(PAD_N - 1)) state_d = WRITE;
      end
`endif
      WRITE: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = col_q[ADDR_WIDTH-1:0];
          data_d = s_data;
          col_d  = col_q + 1'b1;
          if (col_q == last_col_q) begin
`ifdef LINE_WRITER_PAD_EN
            state_d = PAD_R;
`else
            state_d = EOL;
`endif
          end
        end
      end
`ifdef LINE_WRITER_PAD_EN
      PAD_R: begin
        we_d   = 1'b1;
        addr_d = col_q[ADDR_WIDTH-1:0];
        data_d = '0;
        col_d  = col_q + 1'b1;
        if (col_q == last_col_q + CW'(PAD_N)) state_d = EOL;
      end
`endif
      EOL: begin
        eol_d   = 1'b1;
        col_d   = '0;
        line_d  = line_q + 1'b1;
        state_d = (line_q == last_line_q) ? DONE : WAIT_READY;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered write port, one cycle behind the state that produced it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      line_q     <= '0;
      we_p1      <= 1'b0;
      eol_p1     <= 1'b0;
      done_p1    <= 1'b0;
      busy_p1    <= 1'b0;
      wr_addr_p1 <= '0;
      data_p1    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      we_p1      <= we_d;
      eol_p1     <= eol_d;
      done_p1    <= done_d;
      busy_p1    <= (state_q != IDLE);
      wr_addr_p1 <= addr_d;
      data_p1    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lat_en) begin
      last_col_q  <= end_col(line_width);
      last_line_q <= num_lines - 1'b1;
    end
  end

  assign we       = we_p1;
  assign wr_addr  = wr_addr_p1;
  assign data_out = data_p1;
  assign eol      = eol_p1;
  assign done     = done_p1;
  assign busy     = busy_p1;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Bench for line_buffer_writer: frame-level expected-event queue plus directed timing checks.
`timescale 1ns/1ps
module tb_line_buffer_writer;
  localparam int DW = 16;
  localparam int AW = 14;
  localparam int PW = 1;
`ifdef LINE_WRITER_PAD_EN
  localparam int PW_N = PW;
`else
  localparam int PW_N = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, s_valid, s_ready, ready;
  logic [AW-1:0] line_width, num_lines, wr_addr;
  logic [DW-1:0] s_data, data_out;
  logic          we, eol, busy, done;

  always #5 clk = ~clk;

  line_buffer_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PAD_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .line_width(line_width), .num_lines(num_lines),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ready(ready), .we(we),
    .wr_addr(wr_addr), .data_out(data_out), .eol(eol), .busy(busy), .done(done)
  );

  typedef enum logic [1:0] {EV_WR, EV_EOL, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       data;
    bit       pad;
  } ev_t;

  ev_t exp_q[$];
  int  src_q[$];
  int  n_cmp = 0, n_fail = 0;
  bit  bubble = 0, tog = 0, acc_flag = 0;
  int  acc_total = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame as seen by the line buffer: per line, padding zeros, pixels, padding zeros, eol; then done.
  task automatic expect_frame(input int w, input int n, input int base, input int step);
    int p;
    p = base;
    for (int l = 0; l < n; l++) begin
      for (int k = 0; k < PW_N; k++) exp_q.push_back('{EV_WR, k, 0, 1'b1});
      for (int c = 0; c < w; c++) begin
        exp_q.push_back('{EV_WR, c + PW_N, p, 1'b0});
        src_q.push_back(p);
        p += step;
      end
      for (int k = 0; k < PW_N; k++) exp_q.push_back('{EV_WR, PW_N + w + k, 0, 1'b1});
      exp_q.push_back('{EV_EOL, 0, 0, 1'b0});
    end
    exp_q.push_back('{EV_DONE, 0, 0, 1'b0});
  endtask

  task automatic pulse_start(input int w, input int n);
    line_width = AW'(w);
    num_lines  = AW'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_neg(input int which, input string name, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = s_ready;
        1:       ok = eol;
        2:       ok = we;
        default: ok = done;
      endcase
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_frame(input string name, input int limit);
    bit ok;
    wait_neg(3, name, limit, ok);
    if (ok) begin
      chk({name, "_busy_at_done"}, int'(busy), 1);
      @(negedge clk);
      chk({name, "_busy_after_done"}, int'(busy), 0);
      chk({name, "_events_left"}, exp_q.size(), 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_we"}, int'(we), 0);
    chk({name, "_eol"}, int'(eol), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_s_ready"}, int'(s_ready), 0);
    chk({name, "_wr_addr"}, int'(wr_addr), 0);
    chk({name, "_data_out"}, int'(data_out), 0);
  endtask

  // Pixel source: offers the queue front, pops it after a handshake seen by the monitor.
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      tick();
      if (acc_flag && src_q.size() > 0) void'(src_q.pop_front());
      tog = ~tog;
      if (src_q.size() > 0 && (!bubble || tog)) begin
        s_valid = 1'b1;
        s_data  = DW'(src_q[0]);
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Compare process: every cycle, match the write port against the expected event queue.
  initial begin
    bit acc_last, prev_we, prev_eol, acc_now;
    int last_addr, last_data;
    ev_t ev;
    acc_last = 0; prev_we = 0; prev_eol = 0; last_addr = 0; last_data = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        acc_last = 0; prev_we = 0; prev_eol = 0; last_addr = 0; last_data = 0;
        acc_flag = 0;
      end else begin
        if (acc_last) chk("we_after_accept", int'(we), 1);
        if (we) begin
          if (exp_q.size() == 0) chk("spurious_we", int'(we), 0);
          else begin
            ev = exp_q.pop_front();
            chk("wr_kind", int'(ev.kind), int'(EV_WR));
            chk("wr_addr", int'(wr_addr), ev.addr);
            chk("wr_data", int'(data_out), ev.data);
            if (!ev.pad) chk("wr_needs_accept", int'(acc_last), 1);
            last_addr = ev.addr;
            last_data = ev.data;
          end
        end else begin
          chk("addr_hold", int'(wr_addr), last_addr);
          chk("data_hold", int'(data_out), last_data);
        end
        if (eol) begin
          chk("eol_we_low", int'(we), 0);
          chk("eol_after_last_write", int'(prev_we), 1);
          if (exp_q.size() == 0) chk("spurious_eol", int'(eol), 0);
          else begin
            ev = exp_q.pop_front();
            chk("eol_kind", int'(ev.kind), int'(EV_EOL));
          end
        end
        if (done) begin
          chk("done_after_eol", int'(prev_eol), 1);
          if (exp_q.size() == 0) chk("spurious_done", int'(done), 0);
          else begin
            ev = exp_q.pop_front();
            chk("done_kind", int'(ev.kind), int'(EV_DONE));
          end
        end
        acc_now = s_valid && s_ready;
        if (acc_now) acc_total++;
        acc_last = acc_now;
        acc_flag = acc_now;
        prev_we  = we;
        prev_eol = eol;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc0;
    reset = 1'b1; start = 1'b0; ready = 1'b0; line_width = '0; num_lines = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // Basic frame: 4 x 2, pixels 1..8, ready held high.
    ready = 1'b1;
    expect_frame(4, 2, 1, 1);
`ifndef LINE_WRITER_PAD_EN
    chk("model_len", exp_q.size(), 11);
    chk("model_w3_data", exp_q[3].data, 4);
    chk("model_eol_kind", int'(exp_q[4].kind), int'(EV_EOL));
    chk("model_w8_addr", exp_q[8].addr, 3);
    chk("model_w8_data", exp_q[8].data, 8);
`endif
    acc0 = acc_total;
    pulse_start(4, 2);
    wait_frame("basic", 80);
    chk("basic_accepts", acc_total - acc0, 8);
    tick();

    // Ready drops mid-line (no pause), then stays low for a 10-cycle stall after eol.
    expect_frame(4, 2, 11, 1);
    pulse_start(4, 2);
    wait_neg(0, "stall_grant", 20, ok);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midline_s_ready", int'(s_ready), 1);
    end
    @(negedge clk);
    chk("line_end_s_ready", int'(s_ready), 0);
    wait_neg(1, "stall_eol", 20, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_s_ready", int'(s_ready), 0);
      chk("stall_we", int'(we), 0);
    end
    tick();
    ready = 1'b1;
    @(negedge clk);
    chk("pre_grant_s_ready", int'(s_ready), 0);
`ifdef LINE_WRITER_PAD_EN
    repeat (PW) @(negedge clk);
`endif
    @(negedge clk);
    chk("resume_s_ready", int'(s_ready), 1);
    wait_frame("stall", 80);
    tick();

    // Bubbles: s_valid alternates, line_width 3.
    bubble = 1'b1;
    acc0 = acc_total;
    expect_frame(3, 1, 21, 1);
    pulse_start(3, 1);
    wait_frame("bubble", 60);
    chk("bubble_accepts", acc_total - acc0, 3);
    bubble = 1'b0;
    tick();

    // Bad starts: zero width, zero lines, and a start while a frame is running.
    pulse_start(0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_w_busy", int'(busy), 0);
      chk("zero_w_we", int'(we), 0);
      chk("zero_w_s_ready", int'(s_ready), 0);
    end
    tick();
    pulse_start(3, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("zero_n_busy", int'(busy), 0);
    end
    tick();
    expect_frame(2, 2, 31, 1);
    pulse_start(2, 2);
    repeat (2) tick();
    pulse_start(5, 1);
    wait_frame("busy_start", 60);
    tick();

    // Reset mid-line after two writes, then a fresh frame from address 0.
    expect_frame(4, 1, 41, 1);
    pulse_start(4, 1);
    wait_neg(2, "rst_first_we", 20, ok);
    wait_neg(2, "rst_second_we", 5, ok);
    tick();
    reset = 1'b1;
    exp_q.delete();
    src_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midline_reset");
    tick();
    expect_frame(2, 1, 51, 1);
    pulse_start(2, 1);
    wait_frame("after_reset", 40);
    tick();

`ifdef LINE_WRITER_PAD_EN
    // Padding: line_width 2, pixels 7 and 9.
    expect_frame(2, 1, 7, 2);
    chk("pad_model_a0", exp_q[0].addr, 0);
    chk("pad_model_d0", exp_q[0].data, 0);
    chk("pad_model_d1", exp_q[1].data, 7);
    chk("pad_model_d2", exp_q[2].data, 9);
    chk("pad_model_a3", exp_q[3].addr, 3);
    chk("pad_model_d3", exp_q[3].data, 0);
    pulse_start(2, 1);
    wait_frame("pad", 40);
    tick();
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
